// File: rtl/ram_pkg.sv
// Constants and types shared by the 4Kx128 RAM, its writer and its stream reader.
package ram_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 128;
    localparam int LEN_W     = 13;
    localparam int RAM_DEPTH = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // The top word wraps back to address 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM read port plus downstream word stream of the RAM stream reader.
interface ram_stream_reader_if #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
);

    logic              read_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_data_out;

    // A word moves on every cycle with m_valid && m_ready. Once m_valid is
    // raised it stays high, with m_data/m_last frozen, until m_ready is seen.
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output read_en, rd_addr, m_valid, m_data, m_last,
        input  ram_data_out, m_ready
    );

    modport slave (
        input  read_en, rd_addr, m_valid, m_data, m_last,
        output ram_data_out, m_ready
    );

endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry FIFO of {last, data} that soaks up the RAM's one-cycle read latency.
module ram_rd_skid_fifo #(
    parameter int DATA_W = ram_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{last: push_last, data: push_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign valid     = (count_q != 2'd0);
    assign head_data = mem_q[rd_ptr_q].data;
    assign head_last = mem_q[rd_ptr_q].last;

    // The issue throttle upstream must keep these from ever happening.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count_q == 2'd2));
    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        !(pop && count_q == 2'd0));

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a run of RAM words to a valid/ready consumer, keeping at most two
// words outstanding between the RAM read pipeline and the skid FIFO.
module ram_stream_reader #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter int LEN_W  = ram_pkg::LEN_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    ram_stream_reader_if.master bus,
    output ram_pkg::rd_state_t  dbg_state
);

    import ram_pkg::*;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              read_en;
    logic              final_read;
    logic              pop;
    logic [2:0]        occ_next;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_last;

    always_comb begin
        pop = fifo_valid && bus.m_ready;
        // Occupancy the FIFO will have once this cycle's pop and the word
        // already in flight are accounted for; a new read must fit beside it.
        occ_next   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        read_en    = (state_q == RUN) && (rem_q != '0) && (occ_next < 3'd2);
        final_read = read_en && (rem_q == LEN_W'(1));

        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        inflight_d      = read_en;
        inflight_last_d = final_read;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = start_addr;
                    rem_d  = length;
                    if (length != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (read_en) begin
                    addr_d = next_addr(addr_q);
                    rem_d  = rem_q - LEN_W'(1);
                    if (final_read) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the cycle the last word leaves, so done lands right after it.
                if (!inflight_q &&
                    ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop))) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    ram_rd_skid_fifo #(.DATA_W(DATA_W)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (bus.ram_data_out),
        .push_last (inflight_last_q),
        .pop       (pop),
        .count     (fifo_count),
        .valid     (fifo_valid),
        .head_data (fifo_data),
        .head_last (fifo_last)
    );

    assign bus.read_en = read_en;
    assign bus.rd_addr = addr_q;
    assign bus.m_valid = fifo_valid;
    assign bus.m_data  = fifo_data;
    assign bus.m_last  = fifo_last;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule
